adder_operand_stage: RTL and testbench

- Issue stage directly upstream of the 64-bit ALU adder.
- Accepts decoded arithmetic requests over a valid/ready handshake and selects the operand sources (register or sign-extended immediate).
- Forms the adder inputs a, b and c_in for each opcode: subtraction is invert-and-carry, increment is carry-in only.
- Presents a, b and c_in from registers, with a 2-entry skid buffer so the adder-side stall never creates a combinational ready path back to decode.

---
 rtl/alu_pkg.sv | 31 +++
 rtl/operand_former.sv | 80 ++++++++
 rtl/adder_operand_stage.sv | 166 ++++++++++++++++
 tb/tb_adder_operand_stage.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU issue path.
//   - Default widths for the adder datapath, immediate field and sequence tag.
//   - Opcode encoding used by decode and by the operand stage.
//   - Operand bundle handed to the adder (default widths).
// ---------------------------------------------------------------------------
package alu_pkg;

  localparam int ALU_WIDTH     = 64;
  localparam int ALU_IMM_WIDTH = 16;
  localparam int ALU_TAG_WIDTH = 4;

  // 3'b110 and 3'b111 are unassigned and are treated as illegal.
  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_INC  = 3'b010,
    OP_DEC  = 3'b011,
    OP_NEG  = 3'b100,
    OP_PASS = 3'b101
  } op_e;

  typedef struct packed {
    logic [ALU_WIDTH-1:0]     a;
    logic [ALU_WIDTH-1:0]     b;
    logic                     c_in;
    logic [ALU_TAG_WIDTH-1:0] tag;
  } operand_bundle_t;

endpackage

// File: rtl/operand_former.sv
// ---------------------------------------------------------------------------
// operand_former
// Purely combinational mapping from a decoded request to adder inputs.
//   op       : opcode (alu_pkg::op_e encoding)
//   src1     : first register operand
//   src2     : second register operand
//   imm      : immediate field, sign-extended to WIDTH
//   use_imm  : select sign-extended imm instead of src2
//   a, b     : adder operands
//   c_in     : adder carry-in
//   illegal  : opcode is not one of the defined encodings
// ---------------------------------------------------------------------------
module operand_former
  import alu_pkg::*;
#(
  parameter int WIDTH     = ALU_WIDTH,
  parameter int IMM_WIDTH = ALU_IMM_WIDTH
) (
  input  logic [2:0]           op,
  input  logic [WIDTH-1:0]     src1,
  input  logic [WIDTH-1:0]     src2,
  input  logic [IMM_WIDTH-1:0] imm,
  input  logic                 use_imm,
  output logic [WIDTH-1:0]     a,
  output logic [WIDTH-1:0]     b,
  output logic                 c_in,
  output logic                 illegal
);

  logic [WIDTH-1:0] s2;

  // Subtract is a + ~b + 1, increment is a + 0 + 1, decrement adds all-ones,
  // negate is 0 + ~a + 1. Illegal encodings fall through to ADD.
  always_comb begin
    s2      = use_imm ? {{(WIDTH-IMM_WIDTH){imm[IMM_WIDTH-1]}}, imm} : src2;
    a       = src1;
    b       = s2;
    c_in    = 1'b0;
    illegal = 1'b0;
    case (op_e'(op))
      OP_ADD: begin
        a    = src1;
        b    = s2;
        c_in = 1'b0;
      end
      OP_SUB: begin
        a    = src1;
        b    = ~s2;
        c_in = 1'b1;
      end
      OP_INC: begin
        a    = src1;
        b    = '0;
        c_in = 1'b1;
      end
      OP_DEC: begin
        a    = src1;
        b    = '1;
        c_in = 1'b0;
      end
      OP_NEG: begin
        a    = '0;
        b    = ~src1;
        c_in = 1'b1;
      end
      OP_PASS: begin
        a    = src1;
        b    = '0;
        c_in = 1'b0;
      end
      default: begin
        a       = src1;
        b       = s2;
        c_in    = 1'b0;
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/adder_operand_stage.sv
// ---------------------------------------------------------------------------
// adder_operand_stage
// Issue stage in front of the ALU adder. Accepts decoded requests over
// valid/ready, forms a/b/c_in, tags each request with a wrapping sequence
// number and presents the result from registers. A one-entry skid buffer
// behind the output register lets in_ready come straight from a flop.
//   clk, rst_n              : clock, asynchronous active-low reset
//   in_valid / in_ready     : request handshake
//   in_op, in_src1, in_src2 : opcode and register operands
//   in_imm, in_use_imm      : immediate and its select
//   out_valid / out_ready   : adder-side handshake
//   a, b, c_in, out_tag     : registered adder inputs and sequence tag
//   illegal_op              : sticky, set once an illegal opcode is accepted
// ---------------------------------------------------------------------------
module adder_operand_stage
  import alu_pkg::*;
#(
  parameter int WIDTH     = ALU_WIDTH,
  parameter int IMM_WIDTH = ALU_IMM_WIDTH,
  parameter int TAG_WIDTH = ALU_TAG_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2:0]           in_op,
  input  logic [WIDTH-1:0]     in_src1,
  input  logic [WIDTH-1:0]     in_src2,
  input  logic [IMM_WIDTH-1:0] in_imm,
  input  logic                 in_use_imm,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     a,
  output logic [WIDTH-1:0]     b,
  output logic                 c_in,
  output logic [TAG_WIDTH-1:0] out_tag,
  output logic                 illegal_op
);

  typedef struct packed {
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 c_in;
    logic [TAG_WIDTH-1:0] tag;
  } entry_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_TWO   = 2'b10
  } buf_state_e;

  buf_state_e           state_q, state_d;
  entry_t               out_q, out_d;
  entry_t               skid_q, skid_d;
  logic [TAG_WIDTH-1:0] tag_q, tag_d;
  logic                 illegal_q, illegal_d;
  logic                 out_valid_q, out_valid_d;
  logic                 in_ready_q, in_ready_d;

  logic [WIDTH-1:0]     form_a;
  logic [WIDTH-1:0]     form_b;
  logic                 form_c_in;
  logic                 form_illegal;
  entry_t               new_entry;
  logic                 accept;
  logic                 drain;

  operand_former #(
    .WIDTH     (WIDTH),
    .IMM_WIDTH (IMM_WIDTH)
  ) u_former (
    .op      (in_op),
    .src1    (in_src1),
    .src2    (in_src2),
    .imm     (in_imm),
    .use_imm (in_use_imm),
    .a       (form_a),
    .b       (form_b),
    .c_in    (form_c_in),
    .illegal (form_illegal)
  );

  // Next-state for the buffer. in_ready_q is low in ST_TWO, so an accept can
  // only happen in EMPTY or ONE; a drain in TWO promotes the skid entry.
  // in_ready/out_valid are computed from the next state so both leave the
  // stage as plain flops.
  always_comb begin
    accept    = in_valid && in_ready_q;
    drain     = out_valid_q && out_ready;
    new_entry = '{a: form_a, b: form_b, c_in: form_c_in, tag: tag_q};

    state_d   = state_q;
    out_d     = out_q;
    skid_d    = skid_q;
    tag_d     = tag_q;
    illegal_d = illegal_q;

    if (accept) begin
      tag_d = tag_q + TAG_WIDTH'(1);
      if (form_illegal) begin
        illegal_d = 1'b1;
      end
    end

    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          out_d   = new_entry;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        if (accept && drain) begin
          out_d   = new_entry;
        end else if (accept) begin
          skid_d  = new_entry;
          state_d = ST_TWO;
        end else if (drain) begin
          state_d = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (drain) begin
          out_d   = skid_q;
          state_d = ST_ONE;
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase

    out_valid_d = (state_d != ST_EMPTY);
    in_ready_d  = (state_d != ST_TWO);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      out_q       <= '0;
      skid_q      <= '0;
      tag_q       <= '0;
      illegal_q   <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      out_q       <= out_d;
      skid_q      <= skid_d;
      tag_q       <= tag_d;
      illegal_q   <= illegal_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign a          = out_q.a;
  assign b          = out_q.b;
  assign c_in       = out_q.c_in;
  assign out_tag    = out_q.tag;
  assign illegal_op = illegal_q;

endmodule

// File: tb/tb_adder_operand_stage.sv
// ---------------------------------------------------------------------------
// tb_adder_operand_stage
// Directed, table-driven bench for adder_operand_stage with hand-computed
// expected operands, carries, adder sums and tags, plus hand-written
// sequences for backpressure, illegal opcodes, tag wrap and mid-stall reset.
// ---------------------------------------------------------------------------
module tb_adder_operand_stage;

  localparam int WIDTH     = 64;
  localparam int IMM_WIDTH = 16;
  localparam int TAG_WIDTH = 4;

  logic                 clk;
  logic                 rst_n;
  logic                 in_valid;
  logic                 in_ready;
  logic [2:0]           in_op;
  logic [WIDTH-1:0]     in_src1;
  logic [WIDTH-1:0]     in_src2;
  logic [IMM_WIDTH-1:0] in_imm;
  logic                 in_use_imm;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 c_in;
  logic [TAG_WIDTH-1:0] out_tag;
  logic                 illegal_op;

  int checks = 0;
  int errors = 0;

  adder_operand_stage #(
    .WIDTH     (WIDTH),
    .IMM_WIDTH (IMM_WIDTH),
    .TAG_WIDTH (TAG_WIDTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_src1    (in_src1),
    .in_src2    (in_src2),
    .in_imm     (in_imm),
    .in_use_imm (in_use_imm),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .a          (a),
    .b          (b),
    .c_in       (c_in),
    .out_tag    (out_tag),
    .illegal_op (illegal_op)
  );

  // 10 ns clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [63:0] src1;
    logic [63:0] src2;
    logic [15:0] imm;
    logic        use_imm;
    logic [63:0] exp_a;
    logic [63:0] exp_b;
    logic        exp_cin;
    logic [63:0] exp_sum;
  } vec_t;

  vec_t vecs[9];

  // Drives one request onto the input side.
  task automatic applyStimulus(input logic [2:0] op, input logic [63:0] src1,
                               input logic [63:0] src2, input logic [15:0] imm,
                               input logic use_imm);
    in_valid   = 1'b1;
    in_op      = op;
    in_src1    = src1;
    in_src2    = src2;
    in_imm     = imm;
    in_use_imm = use_imm;
  endtask

  // Compares one observed value against its expected value.
  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idleInputs();
    in_valid   = 1'b0;
    in_op      = 3'b000;
    in_src1    = '0;
    in_src2    = '0;
    in_imm     = '0;
    in_use_imm = 1'b0;
  endtask

  logic [63:0] sum;
  logic [63:0] exp_tag;

  initial begin
    // name, op, src1, src2, imm, use_imm, exp_a, exp_b, exp_cin, exp_sum
    vecs[0] = '{"add", 3'b000, 64'd5, 64'd7, 16'h0000, 1'b0,
                64'd5, 64'd7, 1'b0, 64'd12};
    vecs[1] = '{"sub_imm", 3'b001, 64'd10, 64'd0, 16'hFFFD, 1'b1,
                64'd10, 64'd2, 1'b1, 64'd13};
    vecs[2] = '{"inc", 3'b010, 64'h8000_0000_0000_0000, 64'd0, 16'h0000, 1'b0,
                64'h8000_0000_0000_0000, 64'd0, 1'b1, 64'h8000_0000_0000_0001};
    vecs[3] = '{"dec", 3'b011, 64'h8000_0000_0000_0000, 64'd0, 16'h0000, 1'b0,
                64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0,
                64'h7FFF_FFFF_FFFF_FFFF};
    vecs[4] = '{"neg", 3'b100, 64'h8000_0000_0000_0000, 64'd0, 16'h0000, 1'b0,
                64'd0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 64'h8000_0000_0000_0000};
    vecs[5] = '{"pass", 3'b101, 64'h8000_0000_0000_0000, 64'd0, 16'h0000, 1'b0,
                64'h8000_0000_0000_0000, 64'd0, 1'b0, 64'h8000_0000_0000_0000};
    vecs[6] = '{"sub_reg", 3'b001, 64'd3, 64'd5, 16'h0000, 1'b0,
                64'd3, 64'hFFFF_FFFF_FFFF_FFFA, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE};
    vecs[7] = '{"add_imm_pos", 3'b000, 64'd1, 64'd123, 16'h7FFF, 1'b1,
                64'd1, 64'h0000_0000_0000_7FFF, 1'b0, 64'h0000_0000_0000_8000};
    vecs[8] = '{"add_imm_neg", 3'b000, 64'd0, 64'd0, 16'h8000, 1'b1,
                64'd0, 64'hFFFF_FFFF_FFFF_8000, 1'b0, 64'hFFFF_FFFF_FFFF_8000};

    // ---- reset state ----
    idleInputs();
    out_ready = 1'b1;
    rst_n     = 1'b0;
    #12;
    checkOutput("rst_out_valid", {63'd0, out_valid}, 64'd0);
    checkOutput("rst_in_ready", {63'd0, in_ready}, 64'd1);
    checkOutput("rst_a", a, 64'd0);
    checkOutput("rst_b", b, 64'd0);
    checkOutput("rst_c_in", {63'd0, c_in}, 64'd0);
    checkOutput("rst_tag", {60'd0, out_tag}, 64'd0);
    checkOutput("rst_illegal", {63'd0, illegal_op}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // ---- table: back-to-back, one result per cycle, tags from 0 ----
    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i].op, vecs[i].src1, vecs[i].src2, vecs[i].imm,
                    vecs[i].use_imm);
      stepCycle();
      sum = a + b + {63'd0, c_in};
      checkOutput({vecs[i].name, "_valid"}, {63'd0, out_valid}, 64'd1);
      checkOutput({vecs[i].name, "_a"}, a, vecs[i].exp_a);
      checkOutput({vecs[i].name, "_b"}, b, vecs[i].exp_b);
      checkOutput({vecs[i].name, "_cin"}, {63'd0, c_in}, {63'd0, vecs[i].exp_cin});
      checkOutput({vecs[i].name, "_tag"}, {60'd0, out_tag}, 64'(i));
      checkOutput({vecs[i].name, "_sum"}, sum, vecs[i].exp_sum);
      checkOutput({vecs[i].name, "_ready"}, {63'd0, in_ready}, 64'd1);
    end
    idleInputs();
    stepCycle();
    checkOutput("drained_valid", {63'd0, out_valid}, 64'd0);
    checkOutput("idle_hold_a", a, vecs[8].exp_a);
    checkOutput("idle_hold_b", b, vecs[8].exp_b);

    // ---- backpressure: tags 9, 10, 11 ----
    out_ready = 1'b0;
    applyStimulus(3'b000, 64'd1, 64'd1, 16'h0, 1'b0);
    stepCycle();
    applyStimulus(3'b000, 64'd2, 64'd2, 16'h0, 1'b0);
    stepCycle();
    checkOutput("bp_in_ready_low", {63'd0, in_ready}, 64'd0);
    checkOutput("bp_hold_a1", a, 64'd1);
    checkOutput("bp_hold_tag1", {60'd0, out_tag}, 64'd9);
    applyStimulus(3'b000, 64'd3, 64'd3, 16'h0, 1'b0);
    stepCycle();
    checkOutput("bp_still_low", {63'd0, in_ready}, 64'd0);
    checkOutput("bp_still_a1", a, 64'd1);
    checkOutput("bp_still_valid", {63'd0, out_valid}, 64'd1);
    out_ready = 1'b1;
    stepCycle();
    checkOutput("bp_second_a", a, 64'd2);
    checkOutput("bp_second_tag", {60'd0, out_tag}, 64'd10);
    checkOutput("bp_ready_back", {63'd0, in_ready}, 64'd1);
    stepCycle();
    checkOutput("bp_third_a", a, 64'd3);
    checkOutput("bp_third_b", b, 64'd3);
    checkOutput("bp_third_tag", {60'd0, out_tag}, 64'd11);
    idleInputs();
    stepCycle();
    checkOutput("bp_drained", {63'd0, out_valid}, 64'd0);

    // ---- illegal opcode: processed as ADD, sticky flag ----
    applyStimulus(3'b110, 64'd4, 64'd6, 16'h0, 1'b0);
    stepCycle();
    checkOutput("ill_a", a, 64'd4);
    checkOutput("ill_b", b, 64'd6);
    checkOutput("ill_cin", {63'd0, c_in}, 64'd0);
    checkOutput("ill_tag", {60'd0, out_tag}, 64'd12);
    checkOutput("ill_flag", {63'd0, illegal_op}, 64'd1);
    applyStimulus(3'b001, 64'd9, 64'd4, 16'h0, 1'b0);
    stepCycle();
    checkOutput("ill_sticky", {63'd0, illegal_op}, 64'd1);
    checkOutput("ill_next_b", b, 64'hFFFF_FFFF_FFFF_FFFB);
    idleInputs();
    stepCycle();
    checkOutput("ill_sticky_idle", {63'd0, illegal_op}, 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("ill_cleared", {63'd0, illegal_op}, 64'd0);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // ---- tag wrap: 17 accepted requests ----
    for (int i = 0; i < 17; i++) begin
      applyStimulus(3'b101, 64'(i + 100), 64'd0, 16'h0, 1'b0);
      stepCycle();
      exp_tag = 64'(i % 16);
      checkOutput("wrap_tag", {60'd0, out_tag}, exp_tag);
      checkOutput("wrap_a", a, 64'(i + 100));
    end
    idleInputs();
    stepCycle();

    // ---- reset in the middle of a stall ----
    out_ready = 1'b0;
    applyStimulus(3'b000, 64'd20, 64'd1, 16'h0, 1'b0);
    stepCycle();
    applyStimulus(3'b000, 64'd21, 64'd1, 16'h0, 1'b0);
    stepCycle();
    checkOutput("stall_full", {63'd0, in_ready}, 64'd0);
    idleInputs();
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_valid", {63'd0, out_valid}, 64'd0);
    checkOutput("async_rst_ready", {63'd0, in_ready}, 64'd1);
    checkOutput("async_rst_a", a, 64'd0);
    #3;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(3'b010, 64'd41, 64'd0, 16'h0, 1'b0);
    stepCycle();
    checkOutput("post_rst_tag", {60'd0, out_tag}, 64'd0);
    checkOutput("post_rst_a", a, 64'd41);
    checkOutput("post_rst_cin", {63'd0, c_in}, 64'd1);
    idleInputs();
    stepCycle();
    checkOutput("post_rst_drained", {63'd0, out_valid}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
